// File: rtl/quad_decoder_counter_pkg.sv
// Shared types for the quadrature decoder: FSM states and the gray-step move decode.
package quad_decoder_counter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MV_NONE    = 2'd0,
    MV_UP      = 2'd1,
    MV_DOWN    = 2'd2,
    MV_ILLEGAL = 2'd3
  } move_e;

  // {A,B} gray step: A leading (00->10->11->01->00) counts up, B leading counts down.
  function automatic move_e decode_move(input logic [1:0] prev, input logic [1:0] cur);
    move_e mv;
    mv = MV_NONE;
    if (prev != cur) begin
      if ((prev ^ cur) == 2'b11) begin
        mv = MV_ILLEGAL;
      end else begin
        case ({prev, cur})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv = MV_UP;
          default:                                mv = MV_DOWN;
        endcase
      end
    end
    return mv;
  endfunction

endpackage

// File: rtl/quad_decoder_counter_filter.sv
// One encoder phase: synchroniser chain followed by a hold-time glitch filter.
// While i_bypass is high the filter tracks the synchronised level directly.
module quad_decoder_counter_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  input  logic i_bypass,
  output logic o_level
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_level  = r_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  // A new level is accepted only on the FILT_LEN-th consecutive cycle it differs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (i_bypass || (w_synced == r_level)) begin
      r_level <= w_synced;
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= w_synced;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder driving a loadable x4 up/down position counter with
// power-up settling period, sticky illegal-transition flag and step pulse.
module quad_decoder_counter
  import quad_decoder_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] cntr,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int INIT_CYCLES = SYNC_STAGES + FILT_LEN;
  localparam int TW          = $clog2(INIT_CYCLES + 1);
  localparam logic [TW-1:0] INIT_LAST = TW'(INIT_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [TW-1:0]    r_init_cnt;
  logic [1:0]       w_raw;
  logic [1:0]       w_filt;
  logic [1:0]       r_prev;
  logic             w_bypass;
  move_e            w_move;
  logic [WIDTH-1:0] r_cntr;
  logic             r_dir;
  logic             r_step;
  logic             r_err;

  assign w_raw    = {qa, qb};
  assign w_bypass = (r_state == ST_INIT);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_phase
      quad_decoder_counter_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
      ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .i_async (w_raw[gi]),
        .i_bypass(w_bypass),
        .o_level (w_filt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_INIT) && (r_init_cnt == INIT_LAST)) begin
      w_state_next = ST_RUN;
    end
  end

  // Counting is suppressed during INIT so the first settled level never registers as a move.
  always_comb begin
    w_move = MV_NONE;
    if (r_state == ST_RUN) begin
      w_move = decode_move(r_prev, w_filt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 2'b00;
      r_cntr <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_prev <= w_filt;
      r_step <= 1'b0;
      if (load) begin
        r_cntr <= din;
      end else begin
        case (w_move)
          MV_UP: begin
            r_cntr <= r_cntr + 1'b1;
            r_dir  <= 1'b1;
            r_step <= 1'b1;
          end
          MV_DOWN: begin
            r_cntr <= r_cntr - 1'b1;
            r_dir  <= 1'b0;
            r_step <= 1'b1;
          end
          default: ;
        endcase
      end
      if (w_move == MV_ILLEGAL) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign cntr = r_cntr;
  assign dir  = r_dir;
  assign step = r_step;
  assign err  = r_err;

endmodule
